uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte-stream requesters (command responder, ping/heartbeat, sample dump, debug). It grants the transmitter to one requester for a whole packet (through the byte flagged `req_last`), issues one `tx_start` per byte, and waits out each frame on `tx_busy`. A lock timeout frees the transmitter if the owner stalls mid-packet. It sits between the packet producers and the UART TX shift/baud datapath.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rr_picker.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, widths and datapath select constants shared by the UART blocks
package uart_pkg;
    localparam int UART_DATA_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;
    typedef enum logic {ZERO, INCREMENT} cnt_sel_t;
    typedef enum logic {HOLD, SHIFT} shift_sel_t;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: rotate-priority picker, first set request scanning upward from the pointer
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [PW-1:0]      i_rr_ptr,
    output logic [PW-1:0]      o_winner,
    output logic               o_any
);
    logic [PW-1:0] w_idx;
    // Scan from the farthest offset down so the pointer position has the highest priority
    always_comb begin
        o_winner = '0;
        w_idx = '0;
        o_any = |i_req_valid;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((int'(i_rr_ptr) + k) % NUM_REQ);
            if (i_req_valid[w_idx]) o_winner = w_idx;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_tx_busy,
    output logic                          o_tx_start,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_lock_abort
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    state_t r_state, w_next;
    logic [GW-1:0] r_rr_ptr, r_grant_id, w_winner, w_ptr_next;
    logic r_grant_valid, r_last;
    logic [CW-1:0] r_cnt;
    logic w_any, w_grab, w_xfer, w_expire, w_release;
    cnt_sel_t w_cnt_sel;
    logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_byte
        assign w_bytes[g] = i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .PW(GW)) u_picker (
        .i_req_valid (i_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_winner    (w_winner),
        .o_any       (w_any)
    );

    assign w_grab = (r_state == IDLE) && w_any && !i_tx_busy;
    assign w_xfer = (r_state == SEND) && i_req_valid[r_grant_id] && !i_tx_busy;
    assign w_expire = (LOCK_TIMEOUT != 0) && (r_state == SEND) && !w_xfer && (r_cnt == CW'(LOCK_TIMEOUT));
    assign w_release = w_expire || ((r_state == WAIT_DONE) && !i_tx_busy && r_last);
    assign w_ptr_next = (r_grant_id == GW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id = r_grant_id;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Next state: a lock is held from grant through the last byte or a timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_grab ? SEND : IDLE;
            SEND:      w_next = w_xfer ? WAIT_ACK : (w_expire ? IDLE : SEND);
            WAIT_ACK:  w_next = i_tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: w_next = i_tx_busy ? WAIT_DONE : (r_last ? IDLE : SEND);
            default:   w_next = IDLE;
        endcase
    end

    // Outputs: launch, handshake and data move together; counter only runs while stalled in SEND
    always_comb begin
        w_cnt_sel = ((r_state == SEND) && !w_xfer && !w_expire) ? INCREMENT : ZERO;
        o_tx_start = w_xfer;
        o_tx_data = w_xfer ? w_bytes[r_grant_id] : '0;
        o_req_ready = w_xfer ? (NUM_REQ'(1) << r_grant_id) : '0;
        o_lock_abort = w_expire;
    end

    // Grant, pointer, last-byte flag and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr <= '0;
            r_grant_id <= '0;
            r_grant_valid <= 1'b0;
            r_last <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_cnt <= (w_cnt_sel == INCREMENT) ? r_cnt + 1'b1 : '0;
            if (w_grab) begin
                r_grant_id <= w_winner;
                r_grant_valid <= 1'b1;
            end
            if (w_xfer) r_last <= i_req_last[r_grant_id];
            if (w_release) begin
                r_grant_valid <= 1'b0;
                r_rr_ptr <= w_ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a busy-frame transmitter model
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int FRAME = 10;
    localparam int LIMIT = 3000;

    typedef logic [DW:0] src_t [$];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_last = '0;
    logic [N-1:0] req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic tx_busy = 1'b0;
    logic tx_start, grant_valid, lock_abort;
    logic [DW-1:0] tx_data;
    logic [1:0] grant_id;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int fall_cyc = 0;
    int n_abort = 0;
    logic force_busy = 1'b0;
    logic allow_abort = 1'b0;
    logic abort_prev = 1'b0;
    logic start_snap = 1'b0;
    logic [N-1:0] ready_snap = '0;
    logic [10:0] mon_want;
    src_t src_q [N];
    logic [9:0] exp_q [$];

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LOCK_TIMEOUT(TO)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .i_req_last    (req_last),
        .o_req_ready   (req_ready),
        .i_tx_busy     (tx_busy),
        .o_tx_start    (tx_start),
        .o_tx_data     (tx_data),
        .o_grant_valid (grant_valid),
        .o_grant_id    (grant_id),
        .o_lock_abort  (lock_abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive();
        logic [DW:0] head;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = 1'b0;
            req_last[i] = 1'b0;
            req_data[i*DW +: DW] = '0;
            if (src_q[i].size() > 0) begin
                head = src_q[i][0];
                req_valid[i] = 1'b1;
                req_last[i] = head[DW];
                req_data[i*DW +: DW] = head[DW-1:0];
            end
        end
        tx_busy = force_busy || (busy_cnt > 0);
    endtask

    task automatic tick();
        @(negedge clk);
        ready_snap = req_ready;
        start_snap = tx_start;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N; i++)
            if (ready_snap[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (start_snap) busy_cnt = FRAME;
        else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) fall_cyc = cyc;
        end
        drive();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((exp_q.size() > 0 || grant_valid || busy_cnt > 0) && k < LIMIT) begin
            tick();
            k++;
        end
        chk(tag, k < LIMIT, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_data"}, tx_data, 0);
        chk({tag, "_gvalid"}, grant_valid, 0);
        chk({tag, "_gid"}, grant_id, 0);
        chk({tag, "_abort"}, lock_abort, 0);
    endtask

    always @(negedge clk) begin
        if (abort_prev) chk("grant_after_abort", grant_valid, 0);
        abort_prev = lock_abort;
        if (lock_abort) begin
            n_abort++;
            chk("abort_time", cyc - fall_cyc, allow_abort ? 32'd17 : 32'hffffffff);
        end
        if (tx_start) begin
            mon_want = '0;
            if (exp_q.size() > 0) mon_want = {1'b1, exp_q.pop_front()};
            chk("tx_byte", {grant_valid, grant_id, tx_data}, mon_want);
            chk("tx_ready", req_ready, 4'b1 << mon_want[9:8]);
            chk("start_busy", tx_busy, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        src_q[2].push_back({1'b1, 8'h55});
        drive();
        repeat (3) tick();
        chk_reset("por");
        src_q[2].delete();
        reset = 1'b0;
        drive();
        tick();
        chk("idle_nograne", grant_valid, 0);

        src_q[0].push_back({1'b0, 8'hA1});
        src_q[0].push_back({1'b0, 8'hA2});
        src_q[0].push_back({1'b1, 8'hA3});
        exp_q.push_back({2'd0, 8'hA1});
        exp_q.push_back({2'd0, 8'hA2});
        exp_q.push_back({2'd0, 8'hA3});
        drive();
        tick();
        chk("grant_latency", {grant_valid, grant_id}, 3'b100);
        drain("single_drain");
        chk("single_release", grant_valid, 0);

        reset = 1'b1;
        drive();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'h10 * (i + 1))});
        src_q[0].push_back({1'b1, 8'h11});
        for (int i = 0; i < N; i++) exp_q.push_back({2'(i), 8'(8'h10 * (i + 1))});
        exp_q.push_back({2'd0, 8'h11});
        drive();
        drain("fair_drain");

        for (int i = 0; i < 4; i++) src_q[1].push_back({i == 3, 8'(8'hB0 + i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'd1, 8'(8'hB0 + i)});
        drive();
        k = 0;
        while (exp_q.size() > 3 && k < LIMIT) begin
            tick();
            k++;
        end
        chk("lock_first_byte", k < LIMIT, 1);
        src_q[2].push_back({1'b1, 8'hC0});
        src_q[0].push_back({1'b1, 8'hD0});
        exp_q.push_back({2'd2, 8'hC0});
        exp_q.push_back({2'd0, 8'hD0});
        drive();
        drain("lock_drain");

        allow_abort = 1'b1;
        src_q[3].push_back({1'b0, 8'hE0});
        src_q[0].push_back({1'b1, 8'hF0});
        exp_q.push_back({2'd3, 8'hE0});
        exp_q.push_back({2'd0, 8'hF0});
        drive();
        drain("timeout_drain");
        allow_abort = 1'b0;
        chk("abort_count", n_abort, 1);

        force_busy = 1'b1;
        src_q[1].push_back({1'b0, 8'h61});
        src_q[1].push_back({1'b0, 8'h62});
        src_q[1].push_back({1'b1, 8'h63});
        src_q[2].push_back({1'b1, 8'h71});
        drive();
        repeat (20) begin
            tick();
            chk("busy_no_grant", grant_valid, 0);
        end
        force_busy = 1'b0;
        exp_q.push_back({2'd1, 8'h61});
        drive();
        k = 0;
        while (exp_q.size() > 0 && k < LIMIT) begin
            tick();
            k++;
        end
        chk("busy_release_start", k < LIMIT, 1);
        repeat (3) tick();
        chk("midpacket_locked", {grant_valid, grant_id}, 3'b101);
        reset = 1'b1;
        drive();
        tick();
        chk_reset("midreset");
        reset = 1'b0;
        exp_q.push_back({2'd1, 8'h62});
        exp_q.push_back({2'd1, 8'h63});
        exp_q.push_back({2'd2, 8'h71});
        drive();
        drain("post_reset_drain");
        chk("abort_total", n_abort, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
